// File: rtl/muldiv_seq_if.sv
// rtl/muldiv_seq_if.sv - request/result bundle between a core and the muldiv_seq unit
interface muldiv_seq_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        wr_en;
  logic        wr_sel;
  logic [31:0] wr_data;
  logic        rd_req;
  logic        rd_sel;
  logic [31:0] rd_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;
  logic        dbz;

  modport master (
    output start, op, srcA, srcB, wr_en, wr_sel, wr_data, rd_req, rd_sel,
    input  rd_data, hi, lo, busy, done, stall, dbz
  );

  modport slave (
    input  start, op, srcA, srcB, wr_en, wr_sel, wr_data, rd_req, rd_sel,
    output rd_data, hi, lo, busy, done, stall, dbz
  );
endinterface

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative 32x32 mult/multu/div/divu unit with HI/LO registers
module muldiv_seq (
  input  logic         clk,
  input  logic         rst,
  muldiv_seq_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIXUP, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q;
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q, mag_b_q;
  logic [63:0] acc_q;
  logic [31:0] hi_q, lo_q;
  logic        dbz_q;

  logic        busy, done, accept, write_ok;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum, div_trial;
  logic [63:0] mul_next, div_next;
  logic [31:0] res_hi, res_lo;
  logic        res_dbz;

  assign accept   = bus.start & ~busy;
  assign write_ok = bus.wr_en & ~busy & ~bus.start;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept)                state_d = bus.op[1] ? S_DIV : S_MUL;
        else if (state_q == S_DONE) state_d = S_IDLE;
      end
      S_MUL, S_DIV: if (cnt_q == 6'd32) state_d = S_FIXUP;
      S_FIXUP:      state_d = S_DONE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_MUL, S_DIV, S_FIXUP: busy = 1'b1;
      S_DONE:                done = 1'b1;
      default: ;
    endcase
  end

  // Signed ops run on magnitudes; signs are reapplied in FIXUP.
  assign neg_a = ~op_q[0] & a_q[31];
  assign neg_b = ~op_q[0] & b_q[31];
  assign mag_a = neg_a ? (32'd0 - a_q) : a_q;
  assign mag_b = neg_b ? (32'd0 - b_q) : b_q;

  assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_b_q} : 33'd0);
  assign mul_next  = {mul_sum, acc_q[31:1]};
  assign div_trial = {acc_q[63:32], acc_q[31]} - {1'b0, mag_b_q};
  assign div_next  = div_trial[32] ? {acc_q[62:0], 1'b0}
                                   : {div_trial[31:0], acc_q[30:0], 1'b1};

  always_comb begin
    res_hi  = acc_q[63:32];
    res_lo  = acc_q[31:0];
    res_dbz = 1'b0;
    if (!op_q[1]) begin
      {res_hi, res_lo} = (neg_a ^ neg_b) ? (64'd0 - acc_q) : acc_q;
    end else if (b_q == 32'd0) begin
      res_hi  = a_q;
      res_lo  = 32'hFFFF_FFFF;
      res_dbz = 1'b1;
    end else begin
      res_lo = (neg_a ^ neg_b) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
      res_hi = neg_a ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
    end
  end

  // cnt 0 is a setup cycle loading magnitudes; cnt 1..32 are the iterations.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mag_b_q <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      if (accept) begin
        a_q   <= bus.srcA;
        b_q   <= bus.srcB;
        op_q  <= bus.op;
        cnt_q <= '0;
      end
      case (state_q)
        S_MUL, S_DIV: begin
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd0) begin
            acc_q   <= {32'd0, mag_a};
            mag_b_q <= mag_b;
          end else begin
            acc_q <= (state_q == S_MUL) ? mul_next : div_next;
          end
        end
        S_FIXUP: begin
          hi_q  <= res_hi;
          lo_q  <= res_lo;
          dbz_q <= res_dbz;
        end
        default: ;
      endcase
      if (write_ok) begin
        if (bus.wr_sel) hi_q <= bus.wr_data;
        else            lo_q <= bus.wr_data;
      end
    end
  end

  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.dbz     = dbz_q;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.stall   = (bus.rd_req | bus.wr_en) & busy;
  assign bus.rd_data = bus.rd_sel ? hi_q : lo_q;

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk and rst; no other clocks or async paths.
REQ-002 The block SHALL have these ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  request a new mult/div operation
- op  in  2  operation: 0 mult, 1 multu, 2 div, 3 divu
- srcA  in  32  multiplicand / dividend
- srcB  in  32  multiplier / divisor
- wr_en  in  1  mthi/mtlo write request
- wr_sel  in  1  write target: 1 HI, 0 LO
- wr_data  in  32  write data
- rd_req  in  1  mfhi/mflo read request
- rd_sel  in  1  read source: 1 HI, 0 LO
- rd_data  out  32  combinational HI or LO per rd_sel
- hi  out  32  HI register
- lo  out  32  LO register
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- stall  out  1  rd_req or wr_en blocked while busy
- dbz  out  1  last div/divu had divisor zero

Function
REQ-003 The FSM SHALL have states IDLE, MUL, DIV, FIXUP, DONE.
REQ-004 start SHALL be accepted only when busy=0 (IDLE or DONE); when accepted, srcA, srcB and op SHALL be latched, and later input changes SHALL be ignored.
REQ-005 Accepted start SHALL go to MUL for op 0/1 and DIV for op 2/3; start while busy=1 SHALL be ignored with no side effect.
REQ-006 MUL SHALL perform 32 iterations of unsigned shift-add on operand magnitudes, one per cycle.
REQ-007 DIV SHALL perform 32 iterations of restoring division on operand magnitudes, one per cycle.
REQ-008 After the 32nd iteration the FSM SHALL enter FIXUP for one cycle, then DONE for one cycle, then IDLE.
REQ-009 busy SHALL be 1 in MUL, DIV and FIXUP, else 0; done SHALL be 1 only in DONE.
REQ-010 Latency: with start sampled at edge 0, done SHALL be high in the cycle after edge 34, and hi/lo SHALL hold the result from that edge.
REQ-011 hi and lo SHALL update only on the edge entering DONE; during busy they SHALL keep their prior values.
REQ-012 For mult, the 64-bit product SHALL be negated in FIXUP when operand signs differ; multu SHALL use raw unsigned operands.
REQ-013 For mult/multu, the result SHALL be hi = product[63:32] and lo = product[31:0].
REQ-014 For div, lo (quotient) SHALL be negated if operand signs differ, and hi (remainder) SHALL take the sign of the dividend; divu SHALL be unsigned.
REQ-015 div 0x80000000 / 0xFFFFFFFF SHALL yield lo = 0x80000000 and hi = 0, with no flag.
REQ-016 For a divisor of zero (div or divu), the block SHALL take full latency and produce hi = latched srcA, lo = 0xFFFFFFFF, dbz = 1.
REQ-017 dbz SHALL update with hi/lo at every completion, and SHALL be 0 for mult/multu.
REQ-018 rd_data SHALL equal hi when rd_sel=1 and lo otherwise, at all times.
REQ-019 stall SHALL equal (rd_req | wr_en) & busy.
REQ-020 wr_en with busy=0 SHALL write wr_data into the selected register on the next edge; wr_en with busy=1 SHALL be dropped.
REQ-021 If start and wr_en are accepted in the same cycle, start SHALL win and the write SHALL be dropped.
REQ-022 A write in the DONE cycle SHALL take effect after the result lands, overwriting the selected register.

Reset
REQ-023 When rst=1 at an edge, the block SHALL enter IDLE with hi=0, lo=0, busy=0, done=0, dbz=0, and internal accumulators cleared.
REQ-024 rst SHALL take priority over start and wr_en; reset mid-operation SHALL abort it with no done pulse and no hi/lo update.

Verification
REQ-025 multu 0xFFFFFFFF x 0xFFFFFFFF -> done 34 cycles after start, hi=0xFFFFFFFE, lo=0x00000001, dbz=0.
REQ-026 mult 0xFFFFFFFD (-3) x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-027 div 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then divu 100 / 0 -> hi=0x00000064, lo=0xFFFFFFFF, dbz=1.
REQ-028 start at cycle 5 of a running op, plus rd_req=1 and wr_en=1 while busy -> second start ignored, stall=1 each such cycle, write dropped, first result intact.
REQ-029 Idle wr_en=1, wr_sel=1, wr_data=0x12345678 -> hi=0x12345678 next cycle; same-cycle start + wr_en -> write dropped, operation runs.
REQ-030 rst=1 at cycle 10 of a div -> next cycle busy=0, hi=lo=0, dbz=0, no done pulse afterward.
